// File: rtl/csp_dft_scan_responder.sv
// csp_dft_scan_responder: far-end responder for the CSP DFT channel.
// Decodes a one-hot command, consumes scan bits over a four-phase
// return-to-neutral handshake, assembles them LSB-first into a WIDTH-bit
// scan register, and transfers that register to dft_q_o on UPDATE.
// Optional feature macro: CSP_DFT_CAPTURE_EN (RUN->SHIFT loads dft_cap_i
// instead of clearing the scan register).
module csp_dft_scan_responder #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CntW = $clog2(WIDTH + 1)
) (
  input  logic              clk_i,
  input  logic              _RESET,
  input  logic signed [1:0] d_data_i,
  output logic              d_enable_o,
  input  logic [2:0]        c_i,
  input  logic [WIDTH-1:0]  dft_cap_i,
  output logic [WIDTH-1:0]  dft_q_o,
  output logic              dft_update_o,
  output logic [CntW-1:0]   shift_cnt_o,
  output logic              dft_err_o
);

  localparam logic [2:0] CmdRun    = 3'b001;
  localparam logic [2:0] CmdShift  = 3'b010;
  localparam logic [2:0] CmdUpdate = 3'b100;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

  typedef enum logic [1:0] {StHold, StReady, StAck} state_e;

  state_e           state_q;
  logic             enable_q;
  logic [2:0]       c_prev_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] dft_q_q;
  logic             update_q;
  logic [CntW-1:0]  cnt_q;
  logic             err_q;

  logic             c_zero, c_shift, c_bad;
  logic             tok_valid, tok_neutral, tok_illegal;
  logic             consume, upd_edge, load_edge, err_set;
  logic [WIDTH-1:0] load_val;

  // Decode command, token and the edge events seen at the next posedge.
  always_comb begin
    c_zero      = (c_i == 3'b000);
    c_shift     = (c_i == CmdShift);
    c_bad       = !c_zero && !((c_i == CmdRun) || c_shift || (c_i == CmdUpdate));
    // Token encoding: 0/1 valid bit, -1 neutral, -2 illegal.
    tok_valid   = (d_data_i[1] == 1'b0);
    tok_neutral = (d_data_i == 2'sb11);
    tok_illegal = (d_data_i == 2'sb10);
    consume     = (state_q == StReady) && !c_zero && tok_valid;
    upd_edge    = (c_i == CmdUpdate) && (c_prev_q != CmdUpdate);
    load_edge   = (c_prev_q == CmdRun) && c_shift;
    // Bits arriving outside SHIFT, or colliding with the load, are discarded.
    err_set     = c_bad || ((state_q == StReady) && tok_illegal) ||
                  (consume && (!c_shift || load_edge));
`ifdef CSP_DFT_CAPTURE_EN
    load_val    = dft_cap_i;
`else
    load_val    = '0;
`endif
  end

  // Handshake FSM plus scan/update datapath, all outputs registered.
  always_ff @(posedge clk_i or negedge _RESET) begin
    if (!_RESET) begin
      state_q  <= StHold;
      enable_q <= 1'b0;
      c_prev_q <= 3'b000;
      sreg_q   <= '0;
      dft_q_q  <= '0;
      update_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      c_prev_q <= c_i;
      update_q <= upd_edge;
      if (err_set) begin
        err_q <= 1'b1;
      end
      if (upd_edge) begin
        dft_q_q <= sreg_q;
      end

      if (load_edge) begin
        sreg_q <= load_val;
      end else if (consume && c_shift) begin
        sreg_q <= {d_data_i[0], sreg_q[WIDTH-1:1]};
        if (cnt_q != CntMax) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (upd_edge) begin
        cnt_q <= '0;
      end

      unique case (state_q)
        StHold: begin
          if (!c_zero) begin
            state_q  <= StReady;
            enable_q <= 1'b1;
          end
        end
        StReady: begin
          if (c_zero) begin
            state_q  <= StHold;
            enable_q <= 1'b0;
          end else if (tok_valid) begin
            state_q  <= StAck;
            enable_q <= 1'b0;
          end
        end
        StAck: begin
          // Return-to-neutral is always required, whatever C does meanwhile.
          if (tok_neutral) begin
            if (c_zero) begin
              state_q  <= StHold;
              enable_q <= 1'b0;
            end else begin
              state_q  <= StReady;
              enable_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= StHold;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign d_enable_o   = enable_q;
  assign dft_q_o      = dft_q_q;
  assign dft_update_o = update_q;
  assign shift_cnt_o  = cnt_q;
  assign dft_err_o    = err_q;

  // dft_cap_i is only consumed when the capture feature is built in.
`ifndef CSP_DFT_CAPTURE_EN
  logic unused_cap;
  assign unused_cap = ^dft_cap_i;
`endif

endmodule

// File: tb/tb_csp_dft_scan_responder.sv
// Directed self-checking bench for csp_dft_scan_responder (WIDTH = 8).
module tb_csp_dft_scan_responder;

  localparam int unsigned W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [1:0] d_data = -2'sd1;
  logic              d_enable;
  logic [2:0]        c = 3'b000;
  logic [W-1:0]      dft_cap = 8'hA5;
  logic [W-1:0]      dft_q;
  logic              dft_update;
  logic [3:0]        shift_cnt;
  logic              dft_err;

  int vectors = 0;
  int miscompares = 0;

  csp_dft_scan_responder #(.WIDTH(W)) dut (
    .clk_i       (clk),
    ._RESET      (rst_n),
    .d_data_i    (d_data),
    .d_enable_o  (d_enable),
    .c_i         (c),
    .dft_cap_i   (dft_cap),
    .dft_q_o     (dft_q),
    .dft_update_o(dft_update),
    .shift_cnt_o (shift_cnt),
    .dft_err_o   (dft_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tok(input logic b);
    for (int i = 0; i < 20 && !d_enable; i++) step();
    chk("en_wait", {31'd0, d_enable}, 32'd1);
    d_data = {1'b0, b};
    step();
    chk("ack_low", {31'd0, d_enable}, 32'd0);
    d_data = -2'sd1;
    step();
    chk("rearm", {31'd0, d_enable}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] cap_exp;
`ifdef CSP_DFT_CAPTURE_EN
    cap_exp = 8'hFA;
`else
    cap_exp = 8'hF0;
`endif

    // Reset state, then C=RUN arms the handshake one edge later.
    c = 3'b001;
    step();
    step();
    chk("rst_en", {31'd0, d_enable}, 32'd0);
    chk("rst_q", {24'd0, dft_q}, 32'd0);
    chk("rst_upd", {31'd0, dft_update}, 32'd0);
    chk("rst_cnt", {28'd0, shift_cnt}, 32'd0);
    chk("rst_err", {31'd0, dft_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_en", {31'd0, d_enable}, 32'd0);
    step();
    chk("first_en", {31'd0, d_enable}, 32'd1);
    chk("first_err", {31'd0, dft_err}, 32'd0);

    // Shift 1,0,1,1,0,0,0,1 then UPDATE: 8'h8D.
    c = 3'b010;
    step();
    send_tok(1'b1); send_tok(1'b0); send_tok(1'b1); send_tok(1'b1);
    send_tok(1'b0); send_tok(1'b0); send_tok(1'b0); send_tok(1'b1);
    chk("cnt8", {28'd0, shift_cnt}, 32'd8);
    chk("q_before_upd", {24'd0, dft_q}, 32'd0);
    c = 3'b100;
    step();
    chk("upd_q", {24'd0, dft_q}, 32'h8D);
    chk("upd_pulse", {31'd0, dft_update}, 32'd1);
    chk("upd_cnt0", {28'd0, shift_cnt}, 32'd0);
    step();
    chk("upd_once", {31'd0, dft_update}, 32'd0);
    chk("upd_hold_q", {24'd0, dft_q}, 32'h8D);

    // Token in RUN: handshake completes, error set, dft_q kept.
    c = 3'b001;
    send_tok(1'b1);
    chk("run_err", {31'd0, dft_err}, 32'd1);
    chk("run_q", {24'd0, dft_q}, 32'h8D);
    chk("run_cnt", {28'd0, shift_cnt}, 32'd0);
    c = 3'b010;
    step();
    send_tok(1'b1);
    chk("post_cnt", {28'd0, shift_cnt}, 32'd1);
    c = 3'b100;
    step();
    chk("post_q", {24'd0, dft_q}, 32'h80);
    chk("post_upd", {31'd0, dft_update}, 32'd1);

    // Illegal token -2 in READY: sticky error, register untouched.
    c = 3'b000;
    do_reset();
    chk("clr_err", {31'd0, dft_err}, 32'd0);
    c = 3'b010;
    step();
    d_data = -2'sd2;
    step();
    chk("m2_err", {31'd0, dft_err}, 32'd1);
    chk("m2_en", {31'd0, d_enable}, 32'd1);
    chk("m2_cnt", {28'd0, shift_cnt}, 32'd0);
    d_data = -2'sd1;
    step();
    step();
    chk("m2_sticky", {31'd0, dft_err}, 32'd1);

    // Non-one-hot command.
    c = 3'b000;
    do_reset();
    chk("clr_err2", {31'd0, dft_err}, 32'd0);
    c = 3'b011;
    step();
    chk("c011_err", {31'd0, dft_err}, 32'd1);
    c = 3'b010;
    step();
    step();
    chk("c011_sticky", {31'd0, dft_err}, 32'd1);
    chk("c011_q", {24'd0, dft_q}, 32'd0);

    // RUN->SHIFT load, 4 ones, UPDATE.
    c = 3'b000;
    do_reset();
    c = 3'b001;
    step();
    c = 3'b010;
    step();
    send_tok(1'b1); send_tok(1'b1); send_tok(1'b1); send_tok(1'b1);
    chk("cap_cnt", {28'd0, shift_cnt}, 32'd4);
    c = 3'b100;
    step();
    chk("cap_q", {24'd0, dft_q}, {24'd0, cap_exp});
    chk("cap_err", {31'd0, dft_err}, 32'd0);

    // Load 8'h3C, then reset mid-ACK.
    c = 3'b010;
    step();
    send_tok(1'b0); send_tok(1'b0); send_tok(1'b1); send_tok(1'b1);
    send_tok(1'b1); send_tok(1'b1); send_tok(1'b0); send_tok(1'b0);
    c = 3'b100;
    step();
    chk("q3c", {24'd0, dft_q}, 32'h3C);
    c = 3'b010;
    step();
    d_data = 2'sd1;
    step();
    chk("in_ack", {31'd0, d_enable}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_q", {24'd0, dft_q}, 32'd0);
    chk("mid_en", {31'd0, d_enable}, 32'd0);
    chk("mid_cnt", {28'd0, shift_cnt}, 32'd0);
    chk("mid_upd", {31'd0, dft_update}, 32'd0);
    chk("mid_err", {31'd0, dft_err}, 32'd0);
    step();
    rst_n = 1'b1;
    d_data = -2'sd1;
    c = 3'b001;
    step();
    chk("fresh_en", {31'd0, d_enable}, 32'd1);
    c = 3'b010;
    step();
    send_tok(1'b1);
    chk("fresh_cnt", {28'd0, shift_cnt}, 32'd1);
    chk("fresh_err", {31'd0, dft_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
